// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the 480x272 piano LCD, one pixel per clk_lcd.
// Define LCD_STARTUP_DELAY_EN to hold disp_en (and rgb_en) low for the first STARTUP_FRAMES frames.
module lcd_timing_gen #(
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2
) (
  input  logic       clk_lcd,
  input  logic       reset,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       flagh,
  output logic       flagv,
  output logic [9:0] hcount_reg,
  output logic [8:0] Vcount_reg,
  output logic       rgb_en,
  output logic       frame_start,
  output logic       disp_en
);

  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int H_TOTAL = H_END + H_FP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int V_TOTAL = V_END + V_FP;

  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;

  logic       started;
  logic       line_wrap;
  logic [9:0] hc, hc_next;
  logic [8:0] vc, vc_next;
  phase_t     h_state, h_state_next;
  phase_t     v_state, v_state_next;

  logic       hsync_n_d, vsync_n_d, flagh_d, flagv_d, frame_start_d, disp_en_d;
  logic [9:0] hcount_d;
  logic [8:0] vcount_d;

  // Counters hold at zero for the first cycle after reset so that cycle shows position 0.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    hc_next   = '0;
    vc_next   = '0;
    line_wrap = started && (hc == 10'(H_TOTAL - 1));
    if (started) begin
      hc_next = line_wrap ? '0 : hc + 10'd1;
      vc_next = vc;
      if (line_wrap) vc_next = (vc == 9'(V_TOTAL - 1)) ? '0 : vc + 9'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_lcd) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      started <= 1'b0;
      hc      <= '0;
      vc      <= '0;
      h_state <= PH_SYNC;
      v_state <= PH_SYNC;
    end else begin
      started <= 1'b1;
      hc      <= hc_next;
      vc      <= vc_next;
      h_state <= h_state_next;
      v_state <= v_state_next;
    end
  end

  // Next-state logic: phases advance when the next counter value crosses a boundary.
  always_comb begin
    h_state_next = h_state;
    v_state_next = v_state;
    if (!started) begin
      h_state_next = PH_SYNC;
      v_state_next = PH_SYNC;
    end else begin
      unique case (h_state)
        PH_SYNC:   if (hc_next == 10'(H_SYNC))  h_state_next = PH_BACK;
        PH_BACK:   if (hc_next == 10'(H_START)) h_state_next = PH_ACTIVE;
        PH_ACTIVE: if (hc_next == 10'(H_END))   h_state_next = PH_FRONT;
        PH_FRONT:  if (hc_next == '0)           h_state_next = PH_SYNC;
      endcase
      if (line_wrap) begin
        unique case (v_state)
          PH_SYNC:   if (vc_next == 9'(V_SYNC))  v_state_next = PH_BACK;
          PH_BACK:   if (vc_next == 9'(V_START)) v_state_next = PH_ACTIVE;
          PH_ACTIVE: if (vc_next == 9'(V_END))   v_state_next = PH_FRONT;
          PH_FRONT:  if (vc_next == '0)          v_state_next = PH_SYNC;
        endcase
      end
    end
  end

  // Output decode from the next state, registered below so outputs line up with hc/vc.
  always_comb begin
    hsync_n_d     = (h_state_next != PH_SYNC);
    vsync_n_d     = (v_state_next != PH_SYNC);
    flagh_d       = (h_state_next == PH_ACTIVE);
    flagv_d       = (v_state_next == PH_ACTIVE);
    hcount_d      = flagh_d ? hc_next - 10'(H_START) : '0;
    vcount_d      = flagv_d ? vc_next - 9'(V_START) : '0;
    frame_start_d = (hc_next == '0) && (vc_next == '0);
  end

`ifdef LCD_STARTUP_DELAY_EN
  localparam int STARTUP_FRAMES = 4;

  logic [2:0] frame_cnt;

  // Counts frame_start pulses; saturates once the panel has been enabled.
  always_ff @(posedge clk_lcd) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_start_d && (frame_cnt != 3'(STARTUP_FRAMES))) begin
      frame_cnt <= frame_cnt + 3'd1;
    end
  end

  assign disp_en_d = disp_en || (frame_start_d && (frame_cnt == 3'(STARTUP_FRAMES)));
`else
  assign disp_en_d = 1'b1;
`endif

  always_ff @(posedge clk_lcd) begin
    if (reset) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      flagh       <= 1'b0;
      flagv       <= 1'b0;
      hcount_reg  <= '0;
      Vcount_reg  <= '0;
      rgb_en      <= 1'b0;
      frame_start <= 1'b0;
      disp_en     <= 1'b0;
    end else begin
      hsync_n     <= hsync_n_d;
      vsync_n     <= vsync_n_d;
      flagh       <= flagh_d;
      flagv       <= flagv_d;
      hcount_reg  <= hcount_d;
      Vcount_reg  <= vcount_d;
      // One cycle behind the flags, matching the downstream colour register.
      rgb_en      <= flagh && flagv && disp_en_d;
      frame_start <= frame_start_d;
      disp_en     <= disp_en_d;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen (default build): full-size raster plus a tiny raster for frame wrap.
module tb_lcd_timing_gen;

  logic clk_lcd = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_lcd = ~clk_lcd;

  logic       hsync_n, vsync_n, flagh, flagv, rgb_en, frame_start, disp_en;
  logic [9:0] hcount_reg;
  logic [8:0] Vcount_reg;

  logic       sm_hsync_n, sm_vsync_n, sm_flagh, sm_flagv, sm_rgb_en, sm_frame_start, sm_disp_en;
  logic [9:0] sm_hcount;
  logic [8:0] sm_vcount;

  lcd_timing_gen dut (
    .clk_lcd     (clk_lcd),
    .reset       (reset),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .flagh       (flagh),
    .flagv       (flagv),
    .hcount_reg  (hcount_reg),
    .Vcount_reg  (Vcount_reg),
    .rgb_en      (rgb_en),
    .frame_start (frame_start),
    .disp_en     (disp_en)
  );

  // Tiny raster: 10 pixels x 7 lines = 70 cycles per frame.
  lcd_timing_gen #(
    .H_SYNC(3), .H_BP(1), .H_ACTIVE(4), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .V_FP(1)
  ) dut_small (
    .clk_lcd     (clk_lcd),
    .reset       (reset),
    .hsync_n     (sm_hsync_n),
    .vsync_n     (sm_vsync_n),
    .flagh       (sm_flagh),
    .flagv       (sm_flagv),
    .hcount_reg  (sm_hcount),
    .Vcount_reg  (sm_vcount),
    .rgb_en      (sm_rgb_en),
    .frame_start (sm_frame_start),
    .disp_en     (sm_disp_en)
  );

  int n_checked = 0;
  int n_failed  = 0;
  int cyc       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(negedge clk_lcd);
      cyc++;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_hsync_n"}, hsync_n, 1);
    check({pfx, "_vsync_n"}, vsync_n, 1);
    check({pfx, "_flagh"}, flagh, 0);
    check({pfx, "_flagv"}, flagv, 0);
    check({pfx, "_hcount"}, hcount_reg, 0);
    check({pfx, "_vcount"}, Vcount_reg, 0);
    check({pfx, "_rgb_en"}, rgb_en, 0);
    check({pfx, "_frame_start"}, frame_start, 0);
    check({pfx, "_disp_en"}, disp_en, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) @(negedge clk_lcd);
    check_reset_state("rst");

    reset = 1'b0;
    @(negedge clk_lcd);
    cyc = 0;

    // Line 0 of the full raster, and the first two frames of the tiny raster.
    for (int k = 0; k < 525; k++) begin
      check("l0_hsync_n", hsync_n, (k >= 41) ? 1 : 0);
      check("l0_flagh", flagh, (k >= 43 && k <= 522) ? 1 : 0);
      check("l0_hcount", hcount_reg, (k >= 43 && k <= 522) ? k - 43 : 0);
      check("l0_frame_start", frame_start, (k == 0) ? 1 : 0);
      check("l0_vsync_n", vsync_n, 0);
      check("l0_rgb_en", rgb_en, 0);
      check("l0_disp_en", disp_en, 1);
      if (k < 140) begin
        int px, ln;
        px = k % 10;
        ln = (k % 70) / 10;
        check("sm_frame_start", sm_frame_start, (k % 70 == 0) ? 1 : 0);
        check("sm_hsync_n", sm_hsync_n, (px >= 3) ? 1 : 0);
        check("sm_vsync_n", sm_vsync_n, (ln >= 2) ? 1 : 0);
        check("sm_flagh", sm_flagh, (px >= 4 && px <= 7) ? 1 : 0);
        check("sm_hcount", sm_hcount, (px >= 4 && px <= 7) ? px - 4 : 0);
        check("sm_flagv", sm_flagv, (ln >= 3 && ln <= 5) ? 1 : 0);
        check("sm_vcount", sm_vcount, (ln >= 3 && ln <= 5) ? ln - 3 : 0);
      end
      goto_cycle(cyc + 1);
    end

    // Line wrap into line 1.
    check("l1_hsync_n", hsync_n, 0);
    check("l1_vsync_n", vsync_n, 0);
    check("l1_frame_start", frame_start, 0);
    check("l1_hcount", hcount_reg, 0);

    // Vertical sync spans lines 0-9 exactly.
    goto_cycle(9 * 525 + 524);
    check("l9_vsync_n", vsync_n, 0);
    goto_cycle(10 * 525);
    check("l10_vsync_n", vsync_n, 1);
    check("l10_flagv", flagv, 0);
    goto_cycle(11 * 525 + 300);
    check("l11_flagh", flagh, 1);
    check("l11_flagv", flagv, 0);
    check("l11_rgb_en", rgb_en, 0);

    // First active line: rgb_en trails flagh by one cycle.
    goto_cycle(12 * 525);
    for (int k = 0; k < 525; k++) begin
      check("l12_flagv", flagv, 1);
      check("l12_vcount", Vcount_reg, 0);
      check("l12_rgb_en", rgb_en, (k >= 44 && k <= 523) ? 1 : 0);
      goto_cycle(cyc + 1);
    end

    goto_cycle(13 * 525 + 300);
    check("l13_vcount", Vcount_reg, 1);
    check("l13_hcount", hcount_reg, 257);

    // Mid-frame reset at line 100, pixel 200.
    goto_cycle(100 * 525 + 200);
    check("l100_vcount", Vcount_reg, 88);
    check("l100_hcount", hcount_reg, 157);
    check("l100_flagh", flagh, 1);
    check("l100_flagv", flagv, 1);
    check("l100_rgb_en", rgb_en, 1);
    reset = 1'b1;
    goto_cycle(cyc + 1);
    check_reset_state("midrst");
    reset = 1'b0;
    @(negedge clk_lcd);
    cyc = 0;
    check("restart_frame_start", frame_start, 1);
    check("restart_hsync_n", hsync_n, 0);
    check("restart_vsync_n", vsync_n, 0);
    check("restart_flagh", flagh, 0);
    check("restart_flagv", flagv, 0);
    check("restart_hcount", hcount_reg, 0);
    check("restart_vcount", Vcount_reg, 0);
    check("restart_rgb_en", rgb_en, 0);
    check("restart_disp_en", disp_en, 1);
    goto_cycle(1);
    check("restart_frame_start_c1", frame_start, 0);
    goto_cycle(43);
    check("restart_flagh_c43", flagh, 1);
    check("restart_hcount_c43", hcount_reg, 0);
    check("restart_flagv_c43", flagv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
